button_press_classifier: RTL and testbench

//  Consumes debounced level plus p_edge/n_edge pulses from the button debounce/edge stage.

---
 rtl/btn_pkg.sv | 39 +++
 rtl/button_press_classifier_if.sv | 24 ++
 rtl/btn_timer.sv | 32 +++
 rtl/button_press_classifier.sv | 176 +++++++++++++++++
 tb/tb_button_press_classifier.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/btn_pkg.sv
// Shared types and defaults for the button press classifier.
// Holds the FSM state encoding, the event enum and the default cycle counts.
package btn_pkg;

  localparam int LONG_CYCLES_DEF   = 50_000_000;
  localparam int GAP_CYCLES_DEF    = 25_000_000;
  localparam int REPEAT_CYCLES_DEF = 10_000_000;

  // State encoding kept as plain constants so legacy code can compare raw codes.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_PRESS1    = 3'd1;
  localparam state_t ST_LONG_HELD = 3'd2;
  localparam state_t ST_WAIT2     = 3'd3;
  localparam state_t ST_PRESS2    = 3'd4;

  // Event chosen for the next cycle; decoded into the one-cycle output pulses.
  typedef enum logic [2:0] {
    EV_NONE,
    EV_SHORT,
    EV_LONG,
    EV_DOUBLE,
    EV_REPEAT
  } event_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Counter width able to hold every terminal count (largest period minus one).
  function automatic int cnt_width(input int long_c, input int gap_c, input int rep_c);
    int w;
    w = $clog2(max3(long_c, gap_c, rep_c));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_press_classifier_if.sv
// Signal bundle between the debounce/edge stage, the classifier and its consumers.
// master: the side driving the button inputs; slave: the classifier itself.
interface button_press_classifier_if;

  logic level;
  logic p_edge;
  logic n_edge;
  logic short_press;
  logic long_press;
  logic double_click;
  logic repeat_pulse;
  logic busy;

  modport master (
    output level, p_edge, n_edge,
    input  short_press, long_press, double_click, repeat_pulse, busy
  );

  modport slave (
    input  level, p_edge, n_edge,
    output short_press, long_press, double_click, repeat_pulse, busy
  );

endinterface

// File: rtl/btn_timer.sv
// Saturating cycle counter with synchronous clear and count enable.
// tc is high while the count equals tc_value; the caller picks the period per state.
module btn_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] tc_value,
  output logic         tc
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] cnt;

  // Count up while enabled, stop at all-ones instead of wrapping; clear wins.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != CNT_MAX)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = (cnt == tc_value);

endmodule

// File: rtl/button_press_classifier.sv
// Classifies debounced button gestures into short press, long press and double
// click, each reported as a one-cycle registered pulse.
// Optional feature macro: BTN_AUTOREPEAT_EN enables repeat_pulse ticks while a
// long press is held; without it repeat_pulse is tied low.
module button_press_classifier
  import btn_pkg::*;
#(
  parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int GAP_CYCLES    = GAP_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  button_press_classifier_if.slave  bus
);

  localparam int CNT_W = cnt_width(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES);

  localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_TC    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  event_t           ev_nxt;
  logic             t_clear;
  logic             t_enable;
  logic [CNT_W-1:0] tc_value;
  logic             tc;

  logic pe;
  logic ne;
  logic rel;
  logic short_q;
  logic long_q;
  logic double_q;
  logic busy_q;

  // Simultaneous edges are an upstream fault and cancel each other out.
  assign pe  = bus.p_edge & ~bus.n_edge;
  assign ne  = bus.n_edge & ~bus.p_edge;
  // A low level while still holding counts as the release even if n_edge was lost.
  assign rel = ne | ~bus.level;

  // Period compared by the shared timer depends only on the current state.
  assign tc_value = (state == ST_PRESS1) ? LONG_TC :
                    (state == ST_WAIT2)  ? GAP_TC  : REPEAT_TC;

  btn_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (t_clear),
    .enable   (t_enable),
    .tc_value (tc_value),
    .tc       (tc)
  );

`ifdef BTN_AUTOREPEAT_EN
  logic held_entry;
  logic repeat_q;

  // Flags the first cycle spent in LONG_HELD so the repeat period restarts there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_entry <= 1'b0;
    end else begin
      held_entry <= (state_nxt == ST_LONG_HELD) && (state != ST_LONG_HELD);
    end
  end
`endif

  // Next state, next event and timer control for the gesture FSM.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    state_nxt = state;
    ev_nxt    = EV_NONE;
    t_clear   = 1'b0;
    t_enable  = 1'b0;
    case (state)
      ST_IDLE: begin
        t_clear = 1'b1;
        if (pe) begin
          state_nxt = ST_PRESS1;
        end
      end
      ST_PRESS1: begin
        if (rel) begin
          state_nxt = ST_WAIT2;
          t_clear   = 1'b1;
        end else if (tc) begin
          state_nxt = ST_LONG_HELD;
          ev_nxt    = EV_LONG;
          t_clear   = 1'b1;
        end else begin
          t_enable  = 1'b1;
        end
      end
      ST_LONG_HELD: begin
        if (rel) begin
          state_nxt = ST_IDLE;
          t_clear   = 1'b1;
        end
`ifdef BTN_AUTOREPEAT_EN
        else if (held_entry) begin
          t_clear   = 1'b1;
        end else if (tc) begin
          ev_nxt    = EV_REPEAT;
          t_clear   = 1'b1;
        end else begin
          t_enable  = 1'b1;
        end
`endif
      end
      ST_WAIT2: begin
        if (pe) begin
          state_nxt = ST_PRESS2;
          ev_nxt    = EV_DOUBLE;
          t_clear   = 1'b1;
        end else if (tc) begin
          state_nxt = ST_IDLE;
          ev_nxt    = EV_SHORT;
          t_clear   = 1'b1;
        end else begin
          t_enable  = 1'b1;
        end
      end
      ST_PRESS2: begin
        if (rel) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        t_clear   = 1'b1;
      end
    endcase
  end

  // State register plus registered one-hot decode of the chosen event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      short_q  <= (ev_nxt == EV_SHORT);
      long_q   <= (ev_nxt == EV_LONG);
      double_q <= (ev_nxt == EV_DOUBLE);
      busy_q   <= (state_nxt != ST_IDLE);
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  // Registered repeat tick, decoded from the same event as the other pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      repeat_q <= 1'b0;
    end else begin
      repeat_q <= (ev_nxt == EV_REPEAT);
    end
  end

  assign bus.repeat_pulse = repeat_q;
`else
  assign bus.repeat_pulse = 1'b0;
`endif

  assign bus.short_press  = short_q;
  assign bus.long_press   = long_q;
  assign bus.double_click = double_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_button_press_classifier.sv
// Bench for button_press_classifier with LONG=8, GAP=4, REPEAT=3.
// Gestures are lists of (press, release) cycles; the expected pulse trains are
// computed from those times by arithmetic on gesture boundaries.
// Output bit order in obs/exp_v: {short, long, double, repeat, busy}.
module tb_button_press_classifier;

  localparam int L    = 8;
  localparam int G    = 4;
  localparam int R    = 3;
  localparam int MAXC = 256;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  button_press_classifier_if bus ();

  button_press_classifier #(
    .LONG_CYCLES   (L),
    .GAP_CYCLES    (G),
    .REPEAT_CYCLES (R)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int press_q[$];
  int rel_q[$];
  logic [4:0] obs   [MAXC];
  logic [4:0] exp_v [MAXC];

  task automatic check(input string tag, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic bit is_press(input int k);
    foreach (press_q[i]) if (press_q[i] == k) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit is_rel(input int k);
    foreach (rel_q[i]) if (rel_q[i] == k) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit level_at(input int k);
    foreach (press_q[i]) if (k >= press_q[i] && k < rel_q[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void set_bit(input int t, input int b);
    if (t >= 0 && t < MAXC) exp_v[t][b] = 1'b1;
  endfunction

  function automatic void set_busy(input int from_t, input int to_t);
    for (int t = from_t; t <= to_t; t++) set_bit(t, 0);
  endfunction

  // Gesture-level reference: a release later than LONG cycles after the press
  // is a long press; otherwise a following press within GAP cycles of the
  // release is a double click, else a short press once the gap expires.
  function automatic void build_expected();
    int i;
    int p;
    int r;
    for (int t = 0; t < MAXC; t++) exp_v[t] = '0;
    i = 0;
    while (i < press_q.size()) begin
      p = press_q[i];
      r = rel_q[i];
      if (r > p + L) begin
        set_bit(p + L + 1, 3);
`ifdef BTN_AUTOREPEAT_EN
        for (int tt = p + L + R + 2; tt <= r; tt += R) set_bit(tt, 1);
`endif
        set_busy(p + 1, r);
        i++;
      end else if (i + 1 < press_q.size() && press_q[i+1] <= r + G) begin
        set_bit(press_q[i+1] + 1, 2);
        set_busy(p + 1, rel_q[i+1]);
        i += 2;
      end else begin
        set_bit(r + G + 1, 4);
        set_busy(p + 1, r + G);
        i++;
      end
    end
  endfunction

  task automatic clear_gestures();
    press_q.delete();
    rel_q.delete();
  endtask

  task automatic add_gesture(input int p, input int r);
    press_q.push_back(p);
    rel_q.push_back(r);
  endtask

  task automatic apply_reset();
    bus.p_edge = 1'b0;
    bus.n_edge = 1'b0;
    bus.level  = 1'b0;
    reset      = 1'b1;
    repeat (2) @(negedge clk);
    reset      = 1'b0;
  endtask

  // obs[k] is sampled at the negedge before posedge k; inputs for posedge k
  // are applied right after. reset_at >= 0 pulses reset just after posedge
  // reset_at-1 and releases it after the obs[reset_at] sample.
  task automatic run_gestures(input int ncyc, input int reset_at);
    for (int k = 0; k <= ncyc; k++) begin
      obs[k] = {bus.short_press, bus.long_press, bus.double_click,
                bus.repeat_pulse, bus.busy};
      if (k == reset_at) reset = 1'b0;
      bus.p_edge = is_press(k);
      bus.n_edge = is_rel(k);
      bus.level  = level_at(k);
      @(posedge clk);
      if (k + 1 == reset_at) begin
        #1 reset = 1'b1;
      end
      @(negedge clk);
    end
    bus.p_edge = 1'b0;
    bus.n_edge = 1'b0;
    bus.level  = 1'b0;
  endtask

  task automatic compare_all(input string name, input int ncyc);
    build_expected();
    for (int t = 0; t <= ncyc; t++) begin
      check($sformatf("%s@%0d", name, t), int'(obs[t]), int'(exp_v[t]));
      check($sformatf("%s_onehot@%0d", name, t), int'($countones(obs[t][4:1]) <= 1), 1);
    end
  endtask

  task automatic scenario(input string name, input int ncyc);
    apply_reset();
    run_gestures(ncyc, -1);
    compare_all(name, ncyc);
  endtask

  initial begin
    int t;
    int hold;
    int ncyc;

    bus.p_edge = 1'b0;
    bus.n_edge = 1'b0;
    bus.level  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          int'({bus.short_press, bus.long_press, bus.double_click,
                bus.repeat_pulse, bus.busy}), 0);

    // 1: short press, pulse after the full gap
    clear_gestures();
    add_gesture(0, 3);
    scenario("t1", 24);
    check("t1_short@8", int'(obs[8][4]), 1);
    check("t1_short@7", int'(obs[7][4]), 0);
    check("t1_busy@8", int'(obs[8][0]), 0);

    // 2/3: long hold with release at 20
    clear_gestures();
    add_gesture(0, 20);
    scenario("t2", 30);
    check("t2_long@9", int'(obs[9][3]), 1);
    check("t2_short_none", int'(obs[25][4]), 0);
`ifdef BTN_AUTOREPEAT_EN
    check("t2_rep@13", int'(obs[13][1]), 1);
    check("t2_rep@16", int'(obs[16][1]), 1);
    check("t2_rep@19", int'(obs[19][1]), 1);
    check("t2_rep@12", int'(obs[12][1]), 0);
`else
    check("t3_rep@13", int'(obs[13][1]), 0);
    check("t3_rep@16", int'(obs[16][1]), 0);
`endif

    // 4: double click inside the gap window
    clear_gestures();
    add_gesture(0, 2);
    add_gesture(5, 7);
    scenario("t4", 20);
    check("t4_double@6", int'(obs[6][2]), 1);
    check("t4_busy@8", int'(obs[8][0]), 0);

    // 5: second press exactly on the gap terminal-count cycle
    clear_gestures();
    add_gesture(0, 2);
    add_gesture(6, 9);
    scenario("t5", 20);
    check("t5_double@7", int'(obs[7][2]), 1);
    check("t5_short@7", int'(obs[7][4]), 0);

    // 5b: press and release exactly at the long terminal count -> short
    clear_gestures();
    add_gesture(0, L);
    scenario("t5b", 24);
    check("t5b_short", int'(obs[L + G + 1][4]), 1);

    // 6: reset in the middle of a press discards the gesture
    clear_gestures();
    add_gesture(0, 6);
    apply_reset();
    run_gestures(20, 4);
    for (int k = 0; k <= 20; k++) begin
      check($sformatf("t6@%0d", k), int'(obs[k]), (k >= 1 && k <= 3) ? 1 : 0);
    end

    // Randomized gesture streams
    for (int round = 0; round < 8; round++) begin
      clear_gestures();
      t = $urandom_range(0, 3);
      for (int g = 0; g < 5; g++) begin
        hold = $urandom_range(1, L + 3 * R + 1);
        add_gesture(t, t + hold);
        t = t + hold + $urandom_range(1, G + 3);
      end
      ncyc = rel_q[rel_q.size() - 1] + L + G + R + 6;
      scenario($sformatf("rnd%0d", round), ncyc);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
